counter_bank_rr: RTL
====================

Name: counter_bank_rr

Overview:
Parametrised bank of NCH round-robin time-multiplexed counters, all in one clock domain. It replaces the derived-clock counter fan-out with a single-clock bank. A registered selector steps through the unmasked channels and increments one channel per enabled cycle. The block also provides sticky per-channel wrap flags and a registered sum of all channels for downstream monitoring.

Parameters:
NCH, 4, number of counter channels (>=2).
WIDTH, 8, bits per channel counter.
SUM_W, 16, width of sum output; full precision when SUM_W >= WIDTH+$clog2(NCH), otherwise sum taken modulo 2^SUM_W.
SEL_W, $clog2(NCH), selector width (derived, not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  advance: increment selected channel, step selector.
clr  input  1  synchronous clear of counters, selector, wrap flags.
mask  input  NCH  bit i=1 enables channel i in the rotation.
wrap_clr  input  1  synchronous clear of all wrap flags.
sel  output  SEL_W  channel that the next enabled cycle increments.
cnt_bus  output  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
wrap  output  NCH  sticky flag, channel wrapped from all-ones to 0.
sum  output  SUM_W  registered sum of all channel counters.
sum_valid  output  1  sum reflects counters since the last reset/clr.

Behaviour:
- Reset (rst=1, async): all counters 0, sel=0, wrap=0, sum=0, sum_valid=0. All state holds while rst is high.
- Priority per cycle: clr > en. wrap_clr is independent of en.
- clr=1: counters 0, sel=0, wrap=0, sum=0, sum_valid=0 on the next edge. en is ignored in that cycle.
- en=1, clr=0, mask[sel]=1: counter[sel] <= counter[sel]+1 mod 2^WIDTH.
  - If the old value was all-ones, wrap[sel] <= 1.
  - sel <= next index after sel, cyclically, whose mask bit is 1. If sel is the only unmasked channel, sel stays.
- en=1, mask[sel]=0 (mask changed under it): no increment. sel moves to the next unmasked channel after sel.
- mask all zero: no counting; sel holds.
- en=0: counters and sel hold.
- mask changes take effect in the same cycle's next-sel computation. There is no pipeline delay.
- wrap_clr=1 clears all wrap bits. If a wrap event occurs on the same edge, that channel's bit ends at 1 (set wins).
- sum: registered, one-cycle latency. sum(t+1) = sum of all counter values present during cycle t, truncated to SUM_W.
  - Masked channels still contribute their held values.
- sum_valid: goes 1 on the second edge after rst deasserts or clr drops, and stays 1 until the next rst/clr.
- Outputs are all registered. There are no combinational paths from inputs to outputs.
- Widths: increment done at WIDTH bits. The sum is computed at SUM_W bits with zero-extension of each channel.

Test Plan:
- Reset then en=1 for 8 cycles, mask=4'b1111, NCH=4, WIDTH=8 -> each counter=2, sel=0, sum=8 one cycle after the last increment, wrap=0.
- mask=4'b0101, en=1 for 6 cycles from reset -> sel sequence 0,2,0,2,0,2; ch0=3, ch2=3, ch1=ch3=0; sum=6.
- Run channel 0 alone (mask=4'b0001) for 256 enabled cycles -> ch0 wraps to 0, wrap=4'b0001, sel stays 0. Then wrap_clr on the cycle ch0 next wraps (after 256 more) -> wrap[0] remains 1.
- en=1 and clr=1 in the same cycle with ch1=5 -> all counters 0, sel=0, sum_valid=0 next cycle, 1 two cycles after clr drops.
- Assert rst asynchronously mid-count (between edges) with ch2=7 -> outputs reach reset values immediately without a clock edge. With mask=0 and en=1 afterwards, nothing counts.
- SUM_W=9, all four channels driven to 255 -> sum=1020 mod 512=508.

Source files
------------

// File: rtl/counter_bank_rr.sv
// Single-clock bank of round-robin counters: one unmasked channel advances per enabled
// cycle, with sticky wrap flags and a registered running total of all channels.
module counter_bank_rr #(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 8,
    parameter  int SUM_W = 16,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [NCH-1:0]       mask,
    input  logic                 wrap_clr,
    output logic [SEL_W-1:0]     sel,
    output logic [NCH*WIDTH-1:0] cnt_bus,
    output logic [NCH-1:0]       wrap,
    output logic [SUM_W-1:0]     sum,
    output logic                 sum_valid
);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [SEL_W-1:0] sel_q;
    logic [NCH-1:0]   wrap_q;
    logic [SUM_W-1:0] sum_q;
    logic             warm_q;
    logic             valid_q;

    logic [SEL_W-1:0] next_sel;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             adv;
    logic             step;
    logic [NCH-1:0]   wrap_set;
    logic [SUM_W-1:0] total;

    // The selected channel counts only if it is still unmasked; the selector
    // moves whenever any channel is unmasked, skipping a channel masked under it.
    assign adv  = en && mask[sel_q];
    assign step = en && (|mask);

    // First unmasked channel strictly after sel_q, wrapping; k == NCH lands on sel_q itself.
    always_comb begin
        next_sel = sel_q;
        cand     = sel_q;
        found    = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = SEL_W'((int'(sel_q) + k) % NCH);
            if (!found && mask[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        wrap_set = '0;
        if (adv && (cnt_q[sel_q] == {WIDTH{1'b1}})) begin
            wrap_set[sel_q] = 1'b1;
        end
    end

    // Each channel is zero-extended (or truncated) to SUM_W so the total is taken mod 2^SUM_W.
    always_comb begin
        total = '0;
        for (int i = 0; i < NCH; i++) begin
            total = total + SUM_W'(cnt_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (adv) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else if (clr) begin
            sel_q <= '0;
        end else if (step) begin
            sel_q <= next_sel;
        end
    end

    // A wrap on the same edge as wrap_clr survives: the set term is OR-ed after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= '0;
        end else if (clr) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= (wrap_clr ? '0 : wrap_q) | wrap_set;
        end
    end

    // sum_valid rises on the second edge after rst/clr releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            warm_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (clr) begin
            sum_q   <= '0;
            warm_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= total;
            warm_q  <= 1'b1;
            valid_q <= warm_q;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_bus
        assign cnt_bus[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign sel       = sel_q;
    assign wrap      = wrap_q;
    assign sum       = sum_q;
    assign sum_valid = valid_q;

endmodule
